// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-bus layout and occupancy encoding for pipeline stage registers
//   no ports; imported by pipe_slot and pipe_stage_skid
package pipe_pkg;
    localparam int EX_CT_W  = 7;
    localparam int MEM_CT_W = 2;
    localparam int WB_CT_W  = 5;
    localparam int CTRL_W   = EX_CT_W + MEM_CT_W + WB_CT_W;
    // control bus is {ex, mem, wb}, so wb sits at the LSBs
    localparam int REG_WRITE_BIT = 2;
    localparam int MEM_WRITE_BIT = WB_CT_W + 0;
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;
    // skid is only ever valid while main is valid
    function automatic occ_e occ_of(input logic main_v, input logic skid_v);
        return occ_e'({main_v & skid_v, main_v ^ skid_v});
    endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one stage entry holding valid, payload and control
//   clock, clear        : clock, synchronous active-high reset (zeroes everything)
//   load_i              : capture payload_i/ctrl_i and set valid (wins over kill_i)
//   kill_i              : drop valid, payload and ctrl are kept
//   valid_o/payload_o/ctrl_o : held entry
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 64,
    parameter int CTRL_W    = pipe_pkg::CTRL_W
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 load_i,
    input  logic                 kill_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic [CTRL_W-1:0]    ctrl_i,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] payload_o,
    output logic [CTRL_W-1:0]    ctrl_o
);
    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;

    always_comb begin
        valid_d   = load_i ? 1'b1 : kill_i ? 1'b0 : valid_q;
        payload_d = load_i ? payload_i : payload_q;
        ctrl_d    = load_i ? ctrl_i : ctrl_q;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            ctrl_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;
    assign ctrl_o    = ctrl_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with optional skid slot, flush and control kill
//   clock, clear   : clock, synchronous active-high reset
//   flush          : drop every held entry on the next edge
//   in_valid/in_ready/in_payload/in_ctrl     : upstream handshake and entry
//   out_valid/out_ready/out_payload/out_ctrl : downstream handshake and head entry
//   occupancy      : number of held entries, 0..2
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 64,
    parameter int CTRL_W    = pipe_pkg::CTRL_W,
    parameter bit SKID_EN   = 1'b1,
    parameter bit KILL_CTRL = 1'b1
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [1:0]           occupancy
);
    logic                 push, pop, main_v, skid_v, main_load;
    logic [PAYLOAD_W-1:0] main_payload, skid_payload;
    logic [CTRL_W-1:0]    main_ctrl, skid_ctrl;

    assign push = in_valid && in_ready;
    assign pop  = main_v && out_ready;
    // with skid held no push is possible, so main refills from skid on a pop;
    // otherwise a push lands in main only if main is free this cycle
    assign main_load = !flush && (skid_v ? pop : push && (!main_v || pop));

    pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W)) u_main (
        .clock     (clock),
        .clear     (clear),
        .load_i    (main_load),
        .kill_i    (flush || pop),
        .payload_i (skid_v ? skid_payload : in_payload),
        .ctrl_i    (skid_v ? skid_ctrl : in_ctrl),
        .valid_o   (main_v),
        .payload_o (main_payload),
        .ctrl_o    (main_ctrl)
    );

    if (SKID_EN) begin : g_skid
        pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W)) u_skid (
            .clock     (clock),
            .clear     (clear),
            .load_i    (!flush && push && main_v && !pop),
            .kill_i    (flush || pop),
            .payload_i (in_payload),
            .ctrl_i    (in_ctrl),
            .valid_o   (skid_v),
            .payload_o (skid_payload),
            .ctrl_o    (skid_ctrl)
        );
        // skid valid is a flop, so in_ready comes straight from a register
        assign in_ready = !skid_v;
    end else begin : g_noskid
        assign skid_v       = 1'b0;
        assign skid_payload = '0;
        assign skid_ctrl    = '0;
        assign in_ready     = !main_v || out_ready;
    end

    assign out_valid   = main_v;
    assign out_payload = main_payload;
    // a bubble must never carry live write enables downstream
    assign out_ctrl    = KILL_CTRL ? (main_ctrl & {CTRL_W{main_v}}) : main_ctrl;
    assign occupancy   = occ_of(main_v, skid_v);
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for pipe_stage_skid in skid and single-entry modes
module tb_pipe_stage_skid;
    typedef struct packed {
        logic [63:0] p;
        logic [13:0] c;
    } ent_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear;
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_payload, a_out_payload;
    logic [13:0] a_in_ctrl, a_out_ctrl;
    logic [1:0]  a_occ;
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_payload, b_out_payload;
    logic [13:0] b_in_ctrl, b_out_ctrl;
    logic [1:0]  b_occ;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_on  = 1'b0;
    ent_t q[$];

    pipe_stage_skid u_a (
        .clock(clock), .clear(clear), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_payload(a_in_payload), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_payload(a_out_payload), .out_ctrl(a_out_ctrl),
        .occupancy(a_occ)
    );

    pipe_stage_skid #(.SKID_EN(1'b0), .KILL_CTRL(1'b0)) u_b (
        .clock(clock), .clear(clear), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_payload(b_in_payload), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_payload(b_out_payload), .out_ctrl(b_out_ctrl),
        .occupancy(b_occ)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_offer(input logic [63:0] p, input logic [13:0] c);
        a_in_valid   = 1'b1;
        a_in_payload = p;
        a_in_ctrl    = c;
    endtask

    // scoreboard for u_a: inputs are stable at the falling edge and are what the next rising edge samples
    always @(negedge clock) begin
        if (mon_on) begin
            chk("a_occ", 64'(a_occ), 64'(q.size()));
            chk("a_out_valid", 64'(a_out_valid), 64'(q.size() != 0));
            chk("a_in_ready", 64'(a_in_ready), 64'(q.size() < 2));
            if (!a_out_valid) chk("a_bubble_ctrl", 64'(a_out_ctrl), 64'd0);
            if (a_out_valid && a_out_ready) begin
                chk("a_pop_nonempty", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    chk("a_payload", a_out_payload, q[0].p);
                    chk("a_ctrl", 64'(a_out_ctrl), 64'(q[0].c));
                    void'(q.pop_front());
                end
            end
            if (a_flush || clear) q.delete();
            else if (a_in_valid && a_in_ready) q.push_back('{p: a_in_payload, c: a_in_ctrl});
        end
    end

    initial begin
        clear = 1'b1;
        a_flush = 1'b0; a_out_ready = 1'b0; a_offer(64'hDEAD_BEEF, 14'h3FFF);
        b_flush = 1'b0; b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_payload = 64'hDEAD; b_in_ctrl = 14'h3FFF;
        tick();
        tick();
        clear = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_payload", a_out_payload, 64'd0);
        chk("rst_out_ctrl", 64'(a_out_ctrl), 64'd0);
        chk("rst_occ", 64'(a_occ), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        chk("rst_b_occ", 64'(b_occ), 64'd0);
        mon_on = 1'b1;

        // streaming
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_offer(64'(i), 14'(i));
            tick();
            chk("stream_payload", a_out_payload, 64'(i));
            chk("stream_occ", 64'(a_occ), 64'd1);
        end
        a_in_valid = 1'b0;
        tick();
        chk("stream_end_valid", 64'(a_out_valid), 64'd0);

        // skid stall
        a_out_ready = 1'b0;
        a_offer(64'hA, 14'h0A);
        tick();
        chk("stall_in_ready_1", 64'(a_in_ready), 64'd1);
        a_offer(64'hB, 14'h0B);
        tick();
        chk("stall_occ", 64'(a_occ), 64'd2);
        chk("stall_in_ready_0", 64'(a_in_ready), 64'd0);
        chk("stall_head", a_out_payload, 64'hA);
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        chk("unstall_head", a_out_payload, 64'hB);
        chk("unstall_in_ready", 64'(a_in_ready), 64'd1);
        chk("unstall_occ", 64'(a_occ), 64'd1);
        tick();
        chk("unstall_empty", 64'(a_out_valid), 64'd0);

        // flush while full, with a push offered in the flush cycle
        a_out_ready = 1'b0;
        a_offer(64'hD, 14'h1D);
        tick();
        a_offer(64'hE, 14'h1E);
        tick();
        chk("pre_flush_occ", 64'(a_occ), 64'd2);
        a_offer(64'hC, 14'h1C);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        chk("flush_valid", 64'(a_out_valid), 64'd0);
        chk("flush_ctrl", 64'(a_out_ctrl), 64'd0);
        chk("flush_occ", 64'(a_occ), 64'd0);
        chk("flush_in_ready", 64'(a_in_ready), 64'd1);
        chk("flush_payload_kept", a_out_payload, 64'hD);
        a_out_ready = 1'b1;
        tick();
        tick();
        chk("flush_no_c", 64'(a_out_valid), 64'd0);

        // flush together with a pop and an accepted-looking push
        a_offer(64'h31, 14'h31);
        tick();
        a_offer(64'h32, 14'h32);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        chk("flush_pop_occ", 64'(a_occ), 64'd0);
        chk("flush_pop_valid", 64'(a_out_valid), 64'd0);

        // control kill
        a_offer(64'h40, 14'h3FFF);
        tick();
        chk("kill_live_ctrl", 64'(a_out_ctrl), 64'h3FFF);
        a_in_valid = 1'b0;
        tick();
        chk("kill_bubble_valid", 64'(a_out_valid), 64'd0);
        chk("kill_bubble_ctrl", 64'(a_out_ctrl), 64'd0);

        // random traffic; an offer is held unchanged while stalled
        for (int i = 0; i < 400; i++) begin
            automatic logic held = a_in_valid && !a_in_ready;
            if (!held) begin
                a_in_valid   = 1'($urandom_range(0, 1));
                a_in_payload = {$urandom, $urandom};
                a_in_ctrl    = 14'($urandom);
            end
            a_out_ready = ($urandom_range(0, 3) != 0);
            a_flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("a_drain", 64'(q.size()), 64'd0);

        // single-entry mode without control kill
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_payload = 64'h11; b_in_ctrl = 14'h001;
        tick();
        chk("b_occ_1", 64'(b_occ), 64'd1);
        chk("b_in_ready_0", 64'(b_in_ready), 64'd0);
        chk("b_head_11", b_out_payload, 64'h11);
        b_in_payload = 64'h22; b_in_ctrl = 14'h3FFF;
        tick();
        chk("b_stall_occ", 64'(b_occ), 64'd1);
        chk("b_stall_head", b_out_payload, 64'h11);
        b_out_ready = 1'b1;
        #1;
        chk("b_comb_ready", 64'(b_in_ready), 64'd1);
        tick();
        chk("b_popush_occ", 64'(b_occ), 64'd1);
        chk("b_popush_head", b_out_payload, 64'h22);
        chk("b_popush_ctrl", 64'(b_out_ctrl), 64'h3FFF);
        b_in_valid = 1'b0;
        tick();
        chk("b_empty_valid", 64'(b_out_valid), 64'd0);
        chk("b_nokill_ctrl", 64'(b_out_ctrl), 64'h3FFF);
        chk("b_empty_occ", 64'(b_occ), 64'd0);
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1; b_in_payload = 64'(32'h50 + i); b_in_ctrl = 14'(i);
            tick();
            chk("b_stream", b_out_payload, 64'(32'h50 + i));
            chk("b_stream_occ", 64'(b_occ), 64'd1);
        end
        b_in_valid = 1'b0;
        tick();
        chk("b_stream_end", 64'(b_out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
